ay_bus_master: RTL



---
 rtl/ay_bus_pkg.sv | 13 +
 rtl/ay_bus_master_if.sv | 13 +
 rtl/ay_bus_master.sv | 93 +++++++++
 3 files changed

// File: rtl/ay_bus_pkg.sv
// ay_bus_pkg: op codes, AY bus codes and FSM states shared by the bus master and the card decoder
package ay_bus_pkg;
  typedef enum logic [1:0] {OP_WRADDR, OP_WRDATA, OP_RDDATA, OP_NULL} op_e;
  localparam logic [2:0] BUS_IDLE   = 3'b010;
  localparam logic [2:0] BUS_WRADDR = 3'b111;
  localparam logic [2:0] BUS_WRDATA = 3'b110;
  localparam logic [2:0] BUS_RDDATA = 3'b011;
  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_ACTIVE, ST_HOLD, ST_RECOVER, ST_DONE3} state_e;
  function automatic logic [2:0] bus_code(op_e op);
    return op == OP_WRADDR ? BUS_WRADDR : op == OP_WRDATA ? BUS_WRDATA :
           op == OP_RDDATA ? BUS_RDDATA : BUS_IDLE;
  endfunction
endpackage

// File: rtl/ay_bus_master_if.sv
// ay_bus_master_if: single-word request/response port of the AY bus master
interface ay_bus_master_if;
  import ay_bus_pkg::*;
  logic       req_valid;
  logic       req_ready;
  op_e        req_op;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;
  modport master (output req_valid, req_op, req_wdata, input req_ready, rsp_valid, rsp_rdata, busy);
  modport slave  (input req_valid, req_op, req_wdata, output req_ready, rsp_valid, rsp_rdata, busy);
endinterface

// File: rtl/ay_bus_master.sv
// ay_bus_master: turns single-word requests into slow, fully registered AY/YM bus cycles
module ay_bus_master
  import ay_bus_pkg::*;
#(
  parameter int SETUP_CYC   = 2,
  parameter int ACTIVE_CYC  = 24,
  parameter int HOLD_CYC    = 2,
  parameter int RECOVER_CYC = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  ay_bus_master_if.slave  req,
  output logic            aybdir,
  output logic            aybc2,
  output logic            aybc1,
  output logic            aya8,
  output logic            aya9_n,
  inout  wire  [7:0]      ayd
);
  localparam int MAX_AB = SETUP_CYC > ACTIVE_CYC ? SETUP_CYC : ACTIVE_CYC;
  localparam int MAX_HR = HOLD_CYC > RECOVER_CYC ? HOLD_CYC : RECOVER_CYC;
  localparam int CW = $clog2(MAX_AB > MAX_HR ? MAX_AB : MAX_HR) + 1;
  if (SETUP_CYC < 1 || ACTIVE_CYC < 4 || HOLD_CYC < 1 || RECOVER_CYC < 3) begin : g_param_check
    $error("ay_bus_master: timing parameter below minimum");
  end
  state_e state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  op_e op, op_n;
  logic [7:0] wd, wd_n, dout, rdata;
  logic accept, on_bus, oe, rsp_v;
  assign accept = req.req_valid && state == ST_IDLE;
  assign op_n = accept ? req.req_op : op;
  assign wd_n = accept ? req.req_wdata : wd;
  assign on_bus = state_d inside {ST_SETUP, ST_ACTIVE, ST_HOLD};
  assign req.req_ready = state == ST_IDLE;
  assign req.busy = state != ST_IDLE;
  assign req.rsp_valid = rsp_v;
  assign req.rsp_rdata = rdata;
  assign ayd = oe ? dout : 8'hzz;
  always_comb begin
    state_d = state;
    cnt_d = cnt == '0 ? cnt : cnt - CW'(1);
    case (state)
      ST_IDLE: if (accept) begin
        state_d = req.req_op == OP_NULL ? ST_DONE3 : ST_SETUP;
        cnt_d = CW'(SETUP_CYC - 1);
      end
      ST_SETUP: if (cnt == '0) begin
        state_d = ST_ACTIVE;
        cnt_d = CW'(ACTIVE_CYC - 1);
      end
      ST_ACTIVE: if (cnt == '0) begin
        state_d = ST_HOLD;
        cnt_d = CW'(HOLD_CYC - 1);
      end
      ST_HOLD: if (cnt == '0) begin
        state_d = ST_RECOVER;
        cnt_d = CW'(RECOVER_CYC - 1);
      end
      ST_RECOVER: if (cnt == '0) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  // Bus outputs are registered from the next state so they change together with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt <= '0;
      op <= OP_WRADDR;
      wd <= '0;
      {aybdir, aybc2, aybc1} <= BUS_IDLE;
      aya8 <= 1'b0;
      aya9_n <= 1'b1;
      oe <= 1'b0;
      dout <= '0;
      rsp_v <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      op <= op_n;
      wd <= wd_n;
      {aybdir, aybc2, aybc1} <= state_d == ST_ACTIVE ? bus_code(op_n) : BUS_IDLE;
      aya8 <= on_bus;
      aya9_n <= !on_bus;
      oe <= on_bus && op_n != OP_RDDATA;
      dout <= wd_n;
      rsp_v <= (state_d == ST_RECOVER && state != ST_RECOVER) || state_d == ST_DONE3;
      if (state == ST_ACTIVE && cnt == '0) rdata <= op == OP_RDDATA ? ayd : wd;
      else if (state_d == ST_DONE3) rdata <= 8'hFF;
    end
  end
endmodule
